rgb_decoder: RTL and testbench

RGB_DECODER -- requirements
Module: rgb_decoder

---
 rtl/rgb_decoder.sv | 160 ++++++++++++++++
 tb/tb_rgb_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_decoder.sv
// rgb_decoder
// Buffers 2-bit color codes in a small FIFO and shows each one on a
// one-hot RGB LED output for HOLD_CYCLES clock cycles. Codes are shown
// back to back with no gap.
//
// Parameters
//   HOLD_CYCLES : cycles each code is displayed (1..255)
//   FIFO_DEPTH  : code buffer entries (power of two, 2..16)
//   DUTY        : PWM on-count out of 16 (0..16), used only with RGB_PWM_EN
//
// Optional feature macro
//   RGB_PWM_EN  : when defined, a free-running 4-bit counter dims the LEDs
//                 to DUTY/16. When undefined, the LEDs are steady.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   code_valid in   upstream has a code on 'code'
//   code       in   11 red, 10 green, 01 blue, 00 off
//   code_ready out  buffer has room (registered)
//   led_r      out  red LED drive, active-high
//   led_g      out  green LED drive, active-high
//   led_b      out  blue LED drive, active-high
//   busy       out  displaying a code or buffer non-empty
module rgb_decoder #(
  parameter int HOLD_CYCLES = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int DUTY        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic [1:0] code,
  output logic       code_ready,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [7:0]    HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  // Elaboration-time parameter range checks
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("rgb_decoder: HOLD_CYCLES out of range");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rgb_decoder: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (DUTY < 0 || DUTY > 16) begin : g_bad_duty
    $error("rgb_decoder: DUTY out of range");
  end

  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [0:0]    state;
  logic [7:0]    hold_cnt;
  logic [2:0]    rgb;
  logic          push;
  logic          pop;

  function automatic logic [2:0] decode(input logic [1:0] c);
    case (c)
      2'b11:   decode = 3'b100;
      2'b10:   decode = 3'b010;
      2'b01:   decode = 3'b001;
      default: decode = 3'b000;
    endcase
  endfunction

  // code_ready is a register that mirrors (count != FULL), so a push can
  // never land in a full buffer and there is no push-through path.
  assign push = code_valid && code_ready;

  // Pop from IDLE as soon as anything is buffered, or from SHOW exactly when
  // the current hold expires, which gives back-to-back display with no gap.
  assign pop = (count != '0) && ((state == IDLE) || (hold_cnt == 8'd0));

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  // Storage array carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= code;
    end
  end

  // FIFO pointers, occupancy, display FSM and LED register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      code_ready <= 1'b1;
      state      <= IDLE;
      hold_cnt   <= 8'd0;
      rgb        <= 3'b000;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count      <= count_next;
      code_ready <= (count_next != FULL);

      if (pop) begin
        rgb      <= decode(mem[rd_ptr]);
        hold_cnt <= HOLD_LOAD;
        state    <= SHOW;
      end else if (state == SHOW) begin
        if (hold_cnt != 8'd0) begin
          hold_cnt <= hold_cnt - 8'd1;
        end else begin
          state <= IDLE;
          rgb   <= 3'b000;
        end
      end
    end
  end

  assign busy = (state == SHOW) || (count != '0);

`ifdef RGB_PWM_EN
  logic [3:0] pwm_cnt;
  logic       pwm_on;

  // Free-running brightness counter; LEDs are gated while it is >= DUTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign pwm_on = ({1'b0, pwm_cnt} < 5'(DUTY));
  assign {led_r, led_g, led_b} = rgb & {3{pwm_on}};
`else
  assign {led_r, led_g, led_b} = rgb;
`endif

endmodule

// File: tb/tb_rgb_decoder.sv
// tb_rgb_decoder
// Self-checking bench for rgb_decoder. Expected outputs come from a
// timeline model: every accepted code is given a display start edge of
// max(accept edge + 1, end of the previous code's display), and LEDs, busy
// and code_ready are derived from those intervals.
module tb_rgb_decoder;

  localparam int HOLD    = 8;
  localparam int DEPTH   = 4;
  localparam int DUTY_TB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       code_valid;
  logic [1:0] code;
  logic       code_ready;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic       busy;

  rgb_decoder #(
    .HOLD_CYCLES(HOLD),
    .FIFO_DEPTH (DEPTH),
    .DUTY       (DUTY_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code_valid(code_valid),
    .code      (code),
    .code_ready(code_ready),
    .led_r     (led_r),
    .led_g     (led_g),
    .led_b     (led_b),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rst = 0;

  int         q_start[$];
  logic [1:0] q_code[$];

  typedef struct {
    logic [1:0] code;
    logic [2:0] rgb;
  } vec_t;

  vec_t vecs[4];

  function automatic int model_count(input int t);
    int n = 0;
    foreach (q_start[i]) if (q_start[i] > t) n++;
    return n;
  endfunction

  function automatic bit model_showing(input int t);
    bit s = 1'b0;
    foreach (q_start[i]) if (t >= q_start[i] && t < q_start[i] + HOLD) s = 1'b1;
    return s;
  endfunction

  function automatic logic [2:0] model_leds(input int t);
    logic [2:0] v = 3'b000;
    int k;
    foreach (q_start[i]) begin
      if (t >= q_start[i] && t < q_start[i] + HOLD) begin
        k = int'(q_code[i]);
        v = (k == 0) ? 3'b000 : 3'(1 << (k - 1));
      end
    end
`ifdef RGB_PWM_EN
    if (((t - last_rst) % 16) >= DUTY_TB) v = 3'b000;
`endif
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("leds",  {5'b0, led_r, led_g, led_b}, {5'b0, model_leds(cyc)});
    checkOutput("busy",  {7'b0, busy},
                {7'b0, (model_count(cyc) != 0) || model_showing(cyc)});
    checkOutput("ready", {7'b0, code_ready}, {7'b0, model_count(cyc) != DEPTH});
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // compare all outputs 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic r,
                               output logic acc);
    int last_end;
    int st;
    code_valid = v;
    code       = c;
    rst        = r;
    @(posedge clk);
    cyc++;
    acc = 1'b0;
    if (r) begin
      q_start.delete();
      q_code.delete();
      last_rst = cyc;
    end else if (v && model_count(cyc - 1) != DEPTH) begin
      last_end = 0;
      if (q_start.size() > 0) last_end = q_start[$] + HOLD;
      st = (cyc + 1 > last_end) ? cyc + 1 : last_end;
      q_start.push_back(st);
      q_code.push_back(c);
      acc = 1'b1;
    end
    #1;
    checkModel();
  endtask

  logic       acc;
  logic [1:0] six[6];
  int         idx;
  logic       saw_low;

  initial begin
    vecs[0] = '{code: 2'b11, rgb: 3'b100};
    vecs[1] = '{code: 2'b10, rgb: 3'b010};
    vecs[2] = '{code: 2'b01, rgb: 3'b001};
    vecs[3] = '{code: 2'b00, rgb: 3'b000};
    six = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10};

    rst = 1'b1;
    code_valid = 1'b0;
    code = 2'b00;

    // Reset state
    applyStimulus(1'b0, 2'b00, 1'b1, acc);
    checkOutput("rst_leds",  {5'b0, led_r, led_g, led_b}, 8'h00);
    checkOutput("rst_busy",  {7'b0, busy}, 8'h00);
    checkOutput("rst_ready", {7'b0, code_ready}, 8'h01);

    // Single transfer per color: one cycle latency, HOLD cycles shown, then idle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'b00, 1'b1, acc);
      applyStimulus(1'b1, vecs[i].code, 1'b0, acc);
      checkOutput("tbl_latency", {5'b0, led_r, led_g, led_b}, 8'h00);
      for (int k = 0; k < HOLD; k++) begin
        applyStimulus(1'b0, 2'b00, 1'b0, acc);
`ifndef RGB_PWM_EN
        checkOutput("tbl_led", {5'b0, led_r, led_g, led_b}, {5'b0, vecs[i].rgb});
`endif
        checkOutput("tbl_busy", {7'b0, busy}, 8'h01);
      end
      applyStimulus(1'b0, 2'b00, 1'b0, acc);
      checkOutput("tbl_off",  {5'b0, led_r, led_g, led_b}, 8'h00);
      checkOutput("tbl_idle", {7'b0, busy}, 8'h00);
    end

    // Back-to-back 11,10,01,00; ready never drops
    applyStimulus(1'b0, 2'b00, 1'b1, acc);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, vecs[i].code, 1'b0, acc);
      checkOutput("b2b_ready", {7'b0, code_ready}, 8'h01);
    end
    for (int k = 0; k < 4 * HOLD + 4; k++) applyStimulus(1'b0, 2'b00, 1'b0, acc);

    // Six codes with valid held: buffer fills, upstream holds the code
    applyStimulus(1'b0, 2'b00, 1'b1, acc);
    idx = 0;
    saw_low = 1'b0;
    for (int i = 0; i < 200 && idx < 6; i++) begin
      applyStimulus(1'b1, six[idx], 1'b0, acc);
      if (code_ready === 1'b0) saw_low = 1'b1;
      if (acc) idx++;
    end
    checkOutput("six_accepted", 8'(idx), 8'd6);
    checkOutput("six_full_seen", {7'b0, saw_low}, 8'h01);
    for (int k = 0; k < 6 * HOLD + 4; k++) applyStimulus(1'b0, 2'b00, 1'b0, acc);
    checkOutput("six_drained", {7'b0, busy}, 8'h00);

    // Reset mid-display with three codes buffered; transfer during reset dropped
    applyStimulus(1'b0, 2'b00, 1'b1, acc);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, vecs[i].code, 1'b0, acc);
    applyStimulus(1'b1, 2'b11, 1'b1, acc);
    checkOutput("mid_rst_leds",  {5'b0, led_r, led_g, led_b}, 8'h00);
    checkOutput("mid_rst_busy",  {7'b0, busy}, 8'h00);
    checkOutput("mid_rst_ready", {7'b0, code_ready}, 8'h01);
    for (int k = 0; k < 3 * HOLD; k++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, acc);
      checkOutput("post_rst_dark", {5'b0, led_r, led_g, led_b}, 8'h00);
    end

    // Randomized traffic with occasional resets against the timeline model
    applyStimulus(1'b0, 2'b00, 1'b1, acc);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
